mips_cpu_harvard: RTL and testbench
===================================

MIPS_CPU_HARVARD -- requirements
Module: mips_cpu_harvard

Interface
REQ-001 SHALL have parameter: RESET_VECTOR, 32'hBFC00000, address of the first instruction fetched after reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: active  output  1  high while executing; low once halted.
REQ-005 SHALL have port: register_v0  output  32  combinational copy of GPR $2.
REQ-006 SHALL have port: clk_enable  input  1  when low, no architectural state changes.
REQ-007 SHALL have port: instr_address  output  32  current PC, byte address.
REQ-008 SHALL have port: instr_readdata  input  32  instruction at instr_address, valid combinationally in the same cycle.
REQ-009 SHALL have port: data_address  output  32  word-aligned data byte address.
REQ-010 SHALL have port: data_write  output  1  store strobe; memory writes on the rising edge.
REQ-011 SHALL have port: data_read  output  1  load strobe.
REQ-012 SHALL have port: data_writedata  output  32  store data.
REQ-013 SHALL have port: data_readdata  input  32  load data, valid combinationally in the same cycle as data_read.

Function
REQ-014 SHALL be a single-cycle core: one instruction retires per enabled clock edge, with 32 GPRs and $0 hard-wired to 0 (writes to $0 are discarded).
REQ-015 SHALL implement ADDU, SUBU, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, ADDIU, ANDI, ORI, XORI, LUI, SLTI, SLTIU, LW, SW, BEQ, BNE, J, JAL, JR.
REQ-016 SHALL sign-extend immediates for ADDIU, SLTI, SLTIU, LW, SW and branches, and zero-extend them for ANDI, ORI, XORI.
REQ-017 SHALL compute arithmetic modulo 2^32 with no overflow traps.
REQ-018 SHALL have SLT/SLTI write 1 if rs < operand (signed), else 0.
REQ-019 SHALL have SLTU/SLTIU write 1 if rs < operand (unsigned), else 0.
REQ-020 SHALL execute exactly one branch delay slot after every taken or not-taken branch or jump.
REQ-021 SHALL compute the branch target as PC+4+(sext(imm)<<2).
REQ-022 SHALL compute the J/JAL target as {PC+4[31:28], idx, 2'b00}.
REQ-023 SHALL have JAL write PC+8 into $31.
REQ-024 SHALL halt when the PC reaches 32'h00000000 after the delay slot: active drops to 0 in that cycle, no further register or memory writes occur, and register_v0 holds its final value.
REQ-025 SHALL, for LW/SW, drive data_address = rs+sext(imm).
REQ-026 SHALL assert data_read (LW) or data_write (SW) only for that instruction, both low otherwise.
REQ-027 SHALL drive data_writedata = rt.
REQ-028 SHALL treat unimplemented opcodes as NOPs.
REQ-029 SHALL, when clk_enable=0, hold PC, GPRs and the delay-slot state and keep data_write low.

Reset
REQ-030 SHALL, while reset=0, asynchronously force PC=RESET_VECTOR, all GPRs=0, active=1, pending-branch state cleared, and data_write=data_read=0.
REQ-031 SHALL start execution on the first enabled rising edge after reset deasserts; a reset asserted mid-program (including inside a delay slot) restarts from RESET_VECTOR.

Configuration
REQ-032 SHALL, when macro MIPS_MULDIV_EN is defined, add HI/LO registers (reset 0) and MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO (single cycle; divide by zero leaves HI/LO unchanged).
REQ-033 SHALL, when MIPS_MULDIV_EN is undefined, decode those opcodes as NOPs.

Verification
REQ-034 SHALL pass: ADDIU $4,$4,11; SLTI $2,$4,-77; JR $0; NOP -> halt at PC=0 with active=0 and register_v0=0.
REQ-035 SHALL pass: ADDIU $4,$0,-100; SLTI $2,$4,-77; JR $0; NOP -> register_v0=1.
REQ-036 SHALL pass: ADDIU $4,$0,-1; SLTIU $2,$4,1 -> register_v0=0, and SLTU $2,$0,$4 -> register_v0=1.
REQ-037 SHALL pass: LUI $3,0x1234; ORI $3,$3,0x5678; SW $3,4($0); LW $2,4($0); JR $0; NOP -> register_v0=32'h12345678 with data_write high for exactly one cycle.
REQ-038 SHALL pass: BEQ $0,$0,+2 with delay slot ADDIU $2,$0,5 and skipped ADDIU $2,$0,9 -> register_v0=5.
REQ-039 SHALL pass: clk_enable low for 3 cycles mid-program -> instr_address and register_v0 unchanged; reset pulse -> instr_address=32'hBFC00000 and register_v0=0.

Source files
------------

// File: rtl/mips_cpu_harvard.sv
// mips_cpu_harvard: single-cycle MIPS-I subset core with Harvard instruction/data ports.
// Define MIPS_MULDIV_EN to add HI/LO with MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
module mips_cpu_harvard #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  input  logic        clk_enable,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] data_address,
  output logic        data_write,
  output logic        data_read,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);
  logic [31:0] pc, branch_target, pc4, a, b, se, ze, res, jump_target;
  logic [31:0] regs [32];
  logic        branch_pending, jump, wr_en, en;
  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, sh, wr_addr;
  logic [15:0] imm;
`ifdef MIPS_MULDIV_EN
  logic [31:0] hi, lo, hi_n, lo_n;
`endif
  assign op = instr_readdata[31:26];
  assign rs = instr_readdata[25:21];
  assign rt = instr_readdata[20:16];
  assign rd = instr_readdata[15:11];
  assign sh = instr_readdata[10:6];
  assign fn = instr_readdata[5:0];
  assign imm = instr_readdata[15:0];
  assign se = {{16{imm[15]}}, imm};
  assign ze = {16'h0, imm};
  assign a = regs[rs];
  assign b = regs[rt];
  assign pc4 = pc + 32'd4;
  // PC 0 is the halt address; reaching it freezes all architectural state
  assign active = pc != 32'h0;
  assign en = clk_enable && active;
  assign instr_address = pc;
  assign register_v0 = regs[2];
  assign data_address = a + se;
  assign data_writedata = b;
  assign data_read = reset && active && op == 6'h23;
  assign data_write = reset && en && op == 6'h2b;
  always_comb begin
    res = 32'h0;
    wr_en = 1'b0;
    wr_addr = rt;
    jump = 1'b0;
    jump_target = pc4 + {se[29:0], 2'b00};
`ifdef MIPS_MULDIV_EN
    hi_n = hi;
    lo_n = lo;
`endif
    case (op)
      6'h00: begin
        wr_addr = rd;
        wr_en = 1'b1;
        case (fn)
          6'h00: res = b << sh;
          6'h02: res = b >> sh;
          6'h03: res = $signed(b) >>> sh;
          6'h08: begin
            wr_en = 1'b0;
            jump = 1'b1;
            jump_target = a;
          end
          6'h21: res = a + b;
          6'h23: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h26: res = a ^ b;
          6'h2a: res = {31'b0, $signed(a) < $signed(b)};
          6'h2b: res = {31'b0, a < b};
`ifdef MIPS_MULDIV_EN
          6'h10: res = hi;
          6'h12: res = lo;
          6'h11: begin
            wr_en = 1'b0;
            hi_n = a;
          end
          6'h13: begin
            wr_en = 1'b0;
            lo_n = a;
          end
          6'h18: begin
            wr_en = 1'b0;
            {hi_n, lo_n} = {{32{a[31]}}, a} * {{32{b[31]}}, b};
          end
          6'h19: begin
            wr_en = 1'b0;
            {hi_n, lo_n} = {32'h0, a} * {32'h0, b};
          end
          6'h1a: begin
            wr_en = 1'b0;
            if (b != 32'h0) begin
              lo_n = $signed(a) / $signed(b);
              hi_n = $signed(a) % $signed(b);
            end
          end
          6'h1b: begin
            wr_en = 1'b0;
            if (b != 32'h0) begin
              lo_n = a / b;
              hi_n = a % b;
            end
          end
`endif
          default: wr_en = 1'b0;
        endcase
      end
      6'h02: begin
        jump = 1'b1;
        jump_target = {pc4[31:28], instr_readdata[25:0], 2'b00};
      end
      6'h03: begin
        jump = 1'b1;
        jump_target = {pc4[31:28], instr_readdata[25:0], 2'b00};
        wr_en = 1'b1;
        wr_addr = 5'd31;
        res = pc + 32'd8;
      end
      6'h04: jump = a == b;
      6'h05: jump = a != b;
      6'h09: begin
        wr_en = 1'b1;
        res = a + se;
      end
      6'h0a: begin
        wr_en = 1'b1;
        res = {31'b0, $signed(a) < $signed(se)};
      end
      6'h0b: begin
        wr_en = 1'b1;
        res = {31'b0, a < se};
      end
      6'h0c: begin
        wr_en = 1'b1;
        res = a & ze;
      end
      6'h0d: begin
        wr_en = 1'b1;
        res = a | ze;
      end
      6'h0e: begin
        wr_en = 1'b1;
        res = a ^ ze;
      end
      6'h0f: begin
        wr_en = 1'b1;
        res = {imm, 16'h0};
      end
      6'h23: begin
        wr_en = 1'b1;
        res = data_readdata;
      end
      default: wr_en = 1'b0;
    endcase
  end
  // a taken branch/jump arms branch_pending; the delay slot then redirects the PC
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_VECTOR;
      branch_pending <= 1'b0;
      branch_target <= 32'h0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
`ifdef MIPS_MULDIV_EN
      hi <= 32'h0;
      lo <= 32'h0;
`endif
    end else if (en) begin
      pc <= branch_pending ? branch_target : pc4;
      branch_pending <= jump && !branch_pending;
      branch_target <= jump_target;
      if (wr_en && wr_addr != 5'd0) regs[wr_addr] <= res;
`ifdef MIPS_MULDIV_EN
      hi <= hi_n;
      lo <= lo_n;
`endif
    end
  end
endmodule

// File: tb/tb_mips_cpu_harvard.sv
// tb_mips_cpu_harvard: directed and random programs scored against an instruction-level interpreter.
module tb_mips_cpu_harvard;
  localparam logic [31:0] RV = 32'hBFC00000;
  logic clk = 1'b0;
  logic reset, clk_enable, active, data_write, data_read;
  logic [31:0] register_v0, instr_address, instr_readdata, data_address, data_writedata, data_readdata;
  bit [31:0] imem [64];
  bit [31:0] dmem [64];
  logic [31:0] exp_pc [$];
  logic [31:0] exp_st_addr [$];
  logic [31:0] exp_st_data [$];
  logic [31:0] exp_v0;
  int n_checks = 0, n_passed = 0, dw_count = 0, model_stores = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  mips_cpu_harvard #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
    .clk_enable(clk_enable), .instr_address(instr_address), .instr_readdata(instr_readdata),
    .data_address(data_address), .data_write(data_write), .data_read(data_read),
    .data_writedata(data_writedata), .data_readdata(data_readdata)
  );

  assign instr_readdata = (instr_address[31:8] == RV[31:8]) ? imem[instr_address[7:2]] : 32'h0;
  assign data_readdata = dmem[data_address[7:2]];
  always @(posedge clk) if (data_write) dmem[data_address[7:2]] <= data_writedata;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_passed++;
    else $display("FAIL %s: got %h, want %h", name, got, want);
  endtask

  always @(negedge clk) begin
    if (mon_en && reset) begin
      if (!clk_enable) chk("no_write_when_disabled", {31'b0, data_write}, 32'h0);
      else if (active) begin
        if (exp_pc.size() == 0) begin
          n_checks++;
          $display("FAIL pc_extra: got retire at %h, want none", instr_address);
        end else chk("pc", instr_address, exp_pc.pop_front());
        if (data_write) begin
          dw_count++;
          if (exp_st_addr.size() == 0) begin
            n_checks++;
            $display("FAIL store_extra: got store to %h, want none", data_address);
          end else begin
            chk("st_addr", data_address, exp_st_addr.pop_front());
            chk("st_data", data_writedata, exp_st_data.pop_front());
          end
        end
      end
    end
  end

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs, rt, rd, sh);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction
  function automatic logic [4:0] rnd_reg();
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rnd_plain();
    logic [5:0] rfn [10];
    logic [5:0] iop [7];
    int k;
    rfn = '{6'h00, 6'h02, 6'h03, 6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2a, 6'h2b};
    iop = '{6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f};
    k = $urandom_range(0, 9);
    if (k < 4) return enc_r(rfn[$urandom_range(0, 9)], rnd_reg(), rnd_reg(), rnd_reg(), 5'($urandom_range(0, 31)));
    if (k < 8) return enc_i(iop[$urandom_range(0, 6)], rnd_reg(), rnd_reg(), 16'($urandom));
    if (k == 8) return enc_i($urandom_range(0, 1) ? 6'h23 : 6'h2b, rnd_reg(), rnd_reg(), 16'(4 * $urandom_range(0, 16383)));
    return enc_i(6'h3e, rnd_reg(), rnd_reg(), 16'($urandom));
  endfunction

  task automatic clear_imem();
    foreach (imem[j]) imem[j] = 32'h0;
  endtask

  task automatic gen_random(input int n);
    int i, off, lim;
    clear_imem();
    i = 0;
    while (i < n) begin
      if ($urandom_range(0, 5) == 0 && i + 1 < n) begin
        lim = (n - i - 1 < 2) ? n - i - 1 : 2;
        off = $urandom_range(0, lim);
        if ($urandom_range(0, 2) != 0)
          imem[i] = enc_i($urandom_range(0, 1) ? 6'h04 : 6'h05, rnd_reg(), rnd_reg(), 16'(off));
        else
          imem[i] = enc_j($urandom_range(0, 1) ? 6'h02 : 6'h03, RV[27:2] + 26'(i + 1 + off));
        imem[i + 1] = rnd_plain();
        i += 2;
      end else begin
        imem[i] = rnd_plain();
        i++;
      end
    end
    imem[n] = enc_r(6'h08, 5'd0, 5'd0, 5'd0, 5'd0);
  endtask

  // instruction-set interpreter: sequential semantics with a one-instruction delay slot
  task automatic model();
    logic [31:0] r [32];
    logic [31:0] m [64];
    logic [31:0] pc, ins, a, b, se, ze, res, tgt, nt, nxt, addr;
    logic [4:0] dst;
    bit pend, br, wr;
    int steps;
    foreach (r[i]) r[i] = 32'h0;
    foreach (m[i]) m[i] = dmem[i];
    pc = RV; pend = 0; tgt = 0; steps = 0; model_stores = 0;
    exp_pc.delete(); exp_st_addr.delete(); exp_st_data.delete();
    while (pc != 32'h0 && steps < 1000) begin
      ins = (pc[31:8] == RV[31:8]) ? imem[pc[7:2]] : 32'h0;
      exp_pc.push_back(pc);
      a = r[ins[25:21]];
      b = r[ins[20:16]];
      se = {{16{ins[15]}}, ins[15:0]};
      ze = {16'h0, ins[15:0]};
      addr = a + se;
      wr = 1; dst = ins[20:16]; br = 0; res = 0;
      nt = pc + 32'd4 + (se << 2);
      case (ins[31:26])
        6'h00: begin
          dst = ins[15:11];
          case (ins[5:0])
            6'h00: res = b << ins[10:6];
            6'h02: res = b >> ins[10:6];
            6'h03: res = $signed(b) >>> ins[10:6];
            6'h08: begin wr = 0; br = 1; nt = a; end
            6'h21: res = a + b;
            6'h23: res = a - b;
            6'h24: res = a & b;
            6'h25: res = a | b;
            6'h26: res = a ^ b;
            6'h2a: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h2b: res = (a < b) ? 32'd1 : 32'd0;
            default: wr = 0;
          endcase
        end
        6'h02: begin wr = 0; br = 1; nt = ((pc + 32'd4) & 32'hF000_0000) | ({6'b0, ins[25:0]} << 2); end
        6'h03: begin
          br = 1; nt = ((pc + 32'd4) & 32'hF000_0000) | ({6'b0, ins[25:0]} << 2);
          dst = 5'd31; res = pc + 32'd8;
        end
        6'h04: begin wr = 0; br = (a == b); end
        6'h05: begin wr = 0; br = (a != b); end
        6'h09: res = a + se;
        6'h0a: res = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
        6'h0b: res = (a < se) ? 32'd1 : 32'd0;
        6'h0c: res = a & ze;
        6'h0d: res = a | ze;
        6'h0e: res = a ^ ze;
        6'h0f: res = ze << 16;
        6'h23: res = m[addr[7:2]];
        6'h2b: begin
          wr = 0;
          m[addr[7:2]] = b;
          exp_st_addr.push_back(addr);
          exp_st_data.push_back(b);
          model_stores++;
        end
        default: wr = 0;
      endcase
      if (wr && dst != 5'd0) r[dst] = res;
      nxt = pend ? tgt : pc + 32'd4;
      if (br) tgt = nt;
      pend = br;
      pc = nxt;
      steps++;
    end
    exp_v0 = r[2];
  endtask

  task automatic run_prog(input string tag, input bit rnd_en, input bit use_want, input logic [31:0] want);
    model();
    dw_count = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    clk_enable = 1'b0;
    #1;
    chk({tag, "_rst_pc"}, instr_address, RV);
    chk({tag, "_rst_v0"}, register_v0, 32'h0);
    chk({tag, "_rst_active"}, {31'b0, active}, 32'h1);
    chk({tag, "_rst_rw"}, {30'b0, data_write, data_read}, 32'h0);
    #1 reset = 1'b1;
    mon_en = 1'b1;
    for (int c = 0; c < 400 && active; c++) begin
      clk_enable = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(posedge clk);
      #1;
    end
    mon_en = 1'b0;
    clk_enable = 1'b0;
    chk({tag, "_halted"}, {31'b0, active}, 32'h0);
    chk({tag, "_halt_pc"}, instr_address, 32'h0);
    chk({tag, "_v0"}, register_v0, exp_v0);
    if (use_want) chk({tag, "_v0_const"}, register_v0, want);
    chk({tag, "_pc_left"}, exp_pc.size(), 32'h0);
    chk({tag, "_st_left"}, exp_st_addr.size(), 32'h0);
    chk({tag, "_store_cycles"}, dw_count, model_stores);
  endtask

  localparam logic [31:0] JR0 = 32'h0000_0008;

  initial begin
    reset = 1'b0;
    clk_enable = 1'b0;
    #2 reset = 1'b1;

    clear_imem();
    imem[0] = enc_i(6'h09, 5'd4, 5'd4, 16'd11);
    imem[1] = enc_i(6'h0a, 5'd4, 5'd2, 16'hFFB3);
    imem[2] = JR0;
    run_prog("slti_false", 0, 1, 32'h0);

    clear_imem();
    imem[0] = enc_i(6'h09, 5'd0, 5'd4, 16'hFF9C);
    imem[1] = enc_i(6'h0a, 5'd4, 5'd2, 16'hFFB3);
    imem[2] = JR0;
    run_prog("slti_true", 0, 1, 32'h1);

    clear_imem();
    imem[0] = enc_i(6'h09, 5'd0, 5'd4, 16'hFFFF);
    imem[1] = enc_i(6'h0b, 5'd4, 5'd2, 16'h0001);
    imem[2] = JR0;
    run_prog("sltiu", 0, 1, 32'h0);

    clear_imem();
    imem[0] = enc_i(6'h09, 5'd0, 5'd4, 16'hFFFF);
    imem[1] = enc_r(6'h2b, 5'd0, 5'd4, 5'd2, 5'd0);
    imem[2] = JR0;
    run_prog("sltu", 0, 1, 32'h1);

    clear_imem();
    imem[0] = enc_i(6'h0f, 5'd0, 5'd3, 16'h1234);
    imem[1] = enc_i(6'h0d, 5'd3, 5'd3, 16'h5678);
    imem[2] = enc_i(6'h2b, 5'd0, 5'd3, 16'd4);
    imem[3] = enc_i(6'h23, 5'd0, 5'd2, 16'd4);
    imem[4] = JR0;
    run_prog("sw_lw", 0, 1, 32'h1234_5678);
    chk("sw_lw_one_write", dw_count, 32'd1);

    clear_imem();
    imem[0] = enc_i(6'h04, 5'd0, 5'd0, 16'd2);
    imem[1] = enc_i(6'h09, 5'd0, 5'd2, 16'd5);
    imem[2] = enc_i(6'h09, 5'd0, 5'd2, 16'd9);
    imem[3] = JR0;
    run_prog("beq_delay", 1, 1, 32'd5);

    clear_imem();
    imem[0] = enc_i(6'h09, 5'd0, 5'd2, 16'd7);
    imem[1] = enc_i(6'h09, 5'd2, 5'd2, 16'd1);
    imem[2] = enc_i(6'h04, 5'd0, 5'd0, 16'd2);
    imem[3] = enc_i(6'h09, 5'd2, 5'd2, 16'd1);
    imem[4] = enc_i(6'h09, 5'd2, 5'd2, 16'd100);
    imem[5] = JR0;
    @(posedge clk);
    #1 reset = 1'b0;
    #2 reset = 1'b1;
    repeat (3) begin
      clk_enable = 1'b1;
      @(posedge clk);
      #1;
    end
    clk_enable = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("hold_pc", instr_address, RV + 32'd12);
      chk("hold_v0", register_v0, 32'd8);
      chk("hold_dw", {31'b0, data_write}, 32'h0);
    end
    reset = 1'b0;
    #1;
    chk("midrst_pc", instr_address, RV);
    chk("midrst_v0", register_v0, 32'h0);
    chk("midrst_active", {31'b0, active}, 32'h1);
    #1 reset = 1'b1;
    clk_enable = 1'b1;
    @(posedge clk);
    #1;
    chk("restart_pc", instr_address, RV + 32'd4);
    chk("restart_v0", register_v0, 32'd7);
    clk_enable = 1'b0;
    run_prog("delay_full", 1, 1, 32'd9);

    for (int t = 0; t < 24; t++) begin
      gen_random($urandom_range(12, 30));
      run_prog($sformatf("rand%0d", t), t[0], 0, 32'h0);
    end

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end
endmodule
